// File: rtl/uart_pkg.sv
// Shared types and baud-timing helpers for the 8N1 UART.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Clocks per serial bit; integer division truncates toward a slightly fast baud.
  function automatic int calc_cpb(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half(input int cpb);
    return (cpb > 3) ? cpb / 2 : 2;
  endfunction

  function automatic int calc_cnt_w(input int cpb);
    return (cpb > 2) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{RST_VAL}};
    else     sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART with independent TX and RX state machines.
// Define UART_RX_STOP_CHECK_EN to drop received frames whose stop bit samples low.
module uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] data_send,
  input  logic       ena_tx,
  output logic       tx_done,
  output logic [7:0] data_recv,
  output logic       new_rx
);

  localparam int CPB   = calc_cpb(CLK_FREQ, BAUD_RATE);
  localparam int HALF  = calc_half(CPB);
  localparam int CNT_W = calc_cnt_w(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  // ---------------- transmitter ----------------
  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_bit_end;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = 1'b1;
    tx_done_d  = 1'b0;
    tx_bit_end = (tx_cnt_q == CNT_LAST);
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (ena_tx) begin
          tx_shift_d = data_send;
          tx_bit_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_d = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DONE;
        end
      end
      TX_DONE: begin
        tx_cnt_d   = '0;
        tx_done_d  = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;

  // ---------------- receiver ----------------
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       data_recv_q, data_recv_d;
  logic             new_rx_q, new_rx_d;
  logic             rx_prev_q;
  logic             rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (nrst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    data_recv_d = data_recv_q;
    new_rx_d    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_state_d = RX_START;
      end
      // A start bit that has gone high again by mid-bit is a glitch.
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      // Leave at the stop-bit midpoint so a back-to-back start edge is not missed.
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
`ifdef UART_RX_STOP_CHECK_EN
          if (rx_s) begin
            data_recv_d = rx_shift_q;
            new_rx_d    = 1'b1;
          end
`else
          data_recv_d = rx_shift_q;
          new_rx_d    = 1'b1;
`endif
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      data_recv_q <= '0;
      new_rx_q    <= 1'b0;
      rx_prev_q   <= 1'b1;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      data_recv_q <= data_recv_d;
      new_rx_q    <= new_rx_d;
      rx_prev_q   <= rx_s;
    end
  end

  assign data_recv = data_recv_q;
  assign new_rx    = new_rx_q;

endmodule

// File: tb/tb_uart.sv
// Directed bench for the UART: frame timing, back-to-back traffic, glitches, framing errors, duplex and reset.
module tb_uart;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;   // 16
  localparam int HALF      = CPB / 2;
`ifdef UART_RX_STOP_CHECK_EN
  localparam bit STOP_CHECK = 1'b1;
`else
  localparam bit STOP_CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] data_send = 8'h00;
  logic       ena_tx = 1'b0;
  logic       tx_done;
  logic [7:0] data_recv;
  logic       new_rx;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         tx_done_cnt = 0;
  bit         mon_quiet = 1'b0;
  logic [7:0] tx_exp[$];
  logic [7:0] tx_got[$];
  logic [7:0] rx_exp[$];
  logic [7:0] rx_got[$];

  uart #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rx        (rx),
    .tx        (tx),
    .data_send (data_send),
    .ena_tx    (ena_tx),
    .tx_done   (tx_done),
    .data_recv (data_recv),
    .new_rx    (new_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (tx_done === 1'b1) tx_done_cnt <= tx_done_cnt + 1;
    if (new_rx === 1'b1) rx_got.push_back(data_recv);
  end

  // Serial monitor for tx: mid-bit sampling plus tx_done latency from the start-bit fall.
  initial begin : tx_mon
    int         f;
    logic [7:0] b;
    bit         seen;
    forever begin
      @(negedge clk);
      if (!nrst && tx === 1'b0) begin
        f = cyc;
        repeat (HALF) @(negedge clk);
        if (!mon_quiet) check("tx_start_bit", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (!mon_quiet) begin
          check("tx_stop_bit", {31'b0, tx}, 32'd1);
          tx_got.push_back(b);
        end
        seen = 1'b0;
        for (int k = 0; k < CPB && !seen; k++) begin
          @(negedge clk);
          if (tx_done === 1'b1) seen = 1'b1;
        end
        if (!mon_quiet) check("tx_done_latency", seen ? cyc - f : 32'hffff_ffff, 10 * CPB);
      end
    end
  end

  task automatic wait_tx_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12 * CPB && !ok; k++) begin
      @(negedge clk);
      if (tx_done === 1'b1) ok = 1'b1;
    end
  endtask

  // Sends a queue of bytes with ena_tx held high across them; data_send is scrambled after each latch.
  task automatic tx_send(input logic [7:0] vec[$]);
    bit ok;
    if (vec.size() == 0) return;
    @(negedge clk);
    data_send = vec[0];
    ena_tx    = 1'b1;
    @(negedge clk);
    check("tx_before_start", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("tx_start_fall", {31'b0, tx}, 32'd0);
    data_send = ~vec[0];
    for (int i = 0; i < vec.size(); i++) begin
      tx_exp.push_back(vec[i]);
      if (i > 0) begin
        repeat (2) @(negedge clk);
        data_send = ~vec[i];
      end
      wait_tx_done(ok);
      check("tx_done_seen", {31'b0, ok}, 32'd1);
      if (!ok) begin
        ena_tx = 1'b0;
        return;
      end
      if (i + 1 < vec.size()) data_send = vec[i + 1];
      else                    ena_tx    = 1'b0;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit, input bit expect_it);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    if (expect_it) rx_exp.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic check_tx_queue(input string tag);
    check({tag, "_tx_count"}, tx_got.size(), tx_exp.size());
    while (tx_got.size() > 0 && tx_exp.size() > 0)
      check({tag, "_tx_byte"}, tx_got.pop_front(), tx_exp.pop_front());
    tx_got.delete();
    tx_exp.delete();
  endtask

  task automatic check_rx_queue(input string tag);
    check({tag, "_rx_count"}, rx_got.size(), rx_exp.size());
    while (rx_got.size() > 0 && rx_exp.size() > 0)
      check({tag, "_rx_byte"}, rx_got.pop_front(), rx_exp.pop_front());
    rx_got.delete();
    rx_exp.delete();
  endtask

  initial begin : main
    int         done_base;
    int         ntx, nrx, gtx, grx;
    logic [7:0] tv[$];
    logic [7:0] rv[$];

    // Reset
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_tx_done", {31'b0, tx_done}, 32'd0);
    check("rst_new_rx", {31'b0, new_rx}, 32'd0);
    check("rst_data_recv", {24'b0, data_recv}, 32'h00);

    // Single TX: A5 appears on the line as 0,1,0,1,0,0,1,0,1,1
    done_base = tx_done_cnt;
    tv = '{8'hA5};
    tx_send(tv);
    repeat (3 * CPB) @(negedge clk);
    check("single_tx_done_cnt", tx_done_cnt - done_base, 32'd1);
    check_tx_queue("single");

    // Back-to-back TX, no frame after ena_tx drops
    done_base = tx_done_cnt;
    tv = '{8'h00, 8'hFF};
    tx_send(tv);
    repeat (3 * CPB) @(negedge clk);
    check("b2b_tx_done_cnt", tx_done_cnt - done_base, 32'd2);
    check("b2b_tx_idle", {31'b0, tx}, 32'd1);
    check_tx_queue("b2b");

    // Single RX
    rx_send(8'h3C, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    check("rx_hold", {24'b0, data_recv}, 32'h3C);
    check_rx_queue("single");

    // Bad stop bit, idle gap, then a valid frame
    rx_send(8'h55, 1'b0, !STOP_CHECK);
    repeat (2 * CPB) @(negedge clk);
    check("bad_stop_data_recv", {24'b0, data_recv}, STOP_CHECK ? 32'h3C : 32'h55);
    rx_send(8'h12, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    check_rx_queue("bad_stop");

    // Start-bit glitch shorter than half a bit, then a valid frame
    rx = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_rx_count", rx_got.size(), 32'd0);
    rx_send(8'hA7, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    check_rx_queue("glitch");

    // Full duplex random bursts
    for (int it = 0; it < 12; it++) begin
      ntx = $urandom_range(0, 5);
      nrx = $urandom_range(0, 5);
      gtx = $urandom_range(0, 60);
      grx = $urandom_range(0, 60);
      tv.delete();
      rv.delete();
      for (int j = 0; j < ntx; j++) tv.push_back(8'($urandom_range(0, 255)));
      for (int j = 0; j < nrx; j++) rv.push_back(8'($urandom_range(0, 255)));
      fork
        begin
          repeat (gtx) @(negedge clk);
          tx_send(tv);
        end
        begin
          repeat (grx) @(negedge clk);
          foreach (rv[j]) rx_send(rv[j], 1'b1, 1'b1);
        end
      join
    end
    repeat (3 * CPB) @(negedge clk);
    check_tx_queue("duplex");
    check_rx_queue("duplex");

    // Asynchronous reset in the middle of a TX and an RX frame
    @(negedge clk);
    data_send = 8'h81;
    ena_tx    = 1'b1;
    rx        = 1'b0;
    @(negedge clk);
    ena_tx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    mon_quiet = 1'b1;
    done_base = tx_done_cnt;
    #1 nrst = 1'b1;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_tx_done", {31'b0, tx_done}, 32'd0);
    check("midrst_new_rx", {31'b0, new_rx}, 32'd0);
    check("midrst_data_recv", {24'b0, data_recv}, 32'h00);
    @(negedge clk);
    rx   = 1'b1;
    nrst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check("post_rst_tx_idle", {31'b0, tx}, 32'd1);
    check("post_rst_no_done", tx_done_cnt - done_base, 32'd0);
    check("post_rst_no_rx", rx_got.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
